// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one memory port between the IFU and the LSU.
// Buffers one request per requester and routes each response to its owner.
module mem_arbiter #(
  parameter int LSU_PRIO = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        mem_reqValid,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: *_reqValid and mem_reqValid are single-cycle pulses with no
  // ready; fields are valid only with the pulse. A response is a single-cycle
  // pulse that may coincide with the issue pulse.
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_IFU = 2'd1;
  localparam logic [1:0] WAIT_LSU = 2'd2;

  logic [1:0]  state;
  logic        last_grant;  // 1 = LSU was granted last
  logic        ifu_pend;
  logic [31:0] ifu_pend_addr;
  logic        lsu_pend;
  logic [31:0] lsu_pend_addr;
  logic        lsu_pend_wen;
  logic [31:0] lsu_pend_wdata;
  logic [3:0]  lsu_pend_wmask;

  logic        ifu_cand, lsu_cand, grant_lsu, issue;
  logic [31:0] ifu_sel_addr, lsu_sel_addr, lsu_sel_wdata;
  logic        lsu_sel_wen;
  logic [3:0]  lsu_sel_wmask;
  logic        ifu_owns, lsu_owns;

  always_comb begin
    ifu_cand      = ifu_reqValid | ifu_pend;
    lsu_cand      = lsu_reqValid | lsu_pend;
    ifu_sel_addr  = ifu_reqValid ? ifu_addr  : ifu_pend_addr;
    lsu_sel_addr  = lsu_reqValid ? lsu_addr  : lsu_pend_addr;
    lsu_sel_wen   = lsu_reqValid ? lsu_wen   : lsu_pend_wen;
    lsu_sel_wdata = lsu_reqValid ? lsu_wdata : lsu_pend_wdata;
    lsu_sel_wmask = lsu_reqValid ? lsu_wmask : lsu_pend_wmask;
    if (ifu_cand && lsu_cand)
      grant_lsu = (LSU_PRIO != 0) ? 1'b1 : ~last_grant;
    else
      grant_lsu = lsu_cand;
    // Reset gates issue and routing so every output is quiet while held.
    issue    = reset && (state == IDLE) && (ifu_cand || lsu_cand);
    ifu_owns = reset && ((state == WAIT_IFU) || (issue && !grant_lsu));
    lsu_owns = reset && ((state == WAIT_LSU) || (issue && grant_lsu));
  end

  assign mem_reqValid  = issue;
  assign mem_addr      = issue ? (grant_lsu ? lsu_sel_addr : ifu_sel_addr) : 32'h0;
  assign mem_wen       = issue && grant_lsu && lsu_sel_wen;
  assign mem_wdata     = (issue && grant_lsu) ? lsu_sel_wdata : 32'h0;
  assign mem_wmask     = (issue && grant_lsu) ? lsu_sel_wmask : 4'h0;
  assign ifu_respValid = mem_respValid && ifu_owns;
  assign lsu_respValid = mem_respValid && lsu_owns;
  assign ifu_rdata     = mem_rdata;
  assign lsu_rdata     = mem_rdata;
  assign dbg_state     = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      last_grant     <= 1'b0;
      ifu_pend       <= 1'b0;
      ifu_pend_addr  <= 32'h0;
      lsu_pend       <= 1'b0;
      lsu_pend_addr  <= 32'h0;
      lsu_pend_wen   <= 1'b0;
      lsu_pend_wdata <= 32'h0;
      lsu_pend_wmask <= 4'h0;
    end else begin
      // Any live pulse that is not being issued right now goes to its slot.
      if (ifu_reqValid && !(issue && !grant_lsu)) begin
        ifu_pend      <= 1'b1;
        ifu_pend_addr <= ifu_addr;
      end
      if (lsu_reqValid && !(issue && grant_lsu)) begin
        lsu_pend       <= 1'b1;
        lsu_pend_addr  <= lsu_addr;
        lsu_pend_wen   <= lsu_wen;
        lsu_pend_wdata <= lsu_wdata;
        lsu_pend_wmask <= lsu_wmask;
      end
      if (issue) begin
        last_grant <= grant_lsu;
        if (grant_lsu) lsu_pend <= 1'b0;
        else           ifu_pend <= 1'b0;
        if (mem_respValid)  state <= IDLE;
        else if (grant_lsu) state <= WAIT_LSU;
        else                state <= WAIT_IFU;
      end else if (state != IDLE && (mem_respValid || state == 2'd3)) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-to-one arbiter that shares the single SoC memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It accepts one-cycle request pulses from each requester and buffers a request that arrives while the port is busy. It forwards one transaction at a time downstream and routes each response back to the requester that owns it. It sits between the IFU/LSU and the memory/interconnect port, replacing the IFU's direct connection to that port.

## Interface
Parameters:
- LSU_PRIO, default 1: 1 = LSU wins simultaneous candidates; 0 = round-robin (winner is the requester not granted last).

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets)
- ifu_reqValid  in  1  one-cycle pulse starting an IFU read
- ifu_addr  in  32  IFU read address, valid with ifu_reqValid
- ifu_respValid  out  1  IFU read data valid
- ifu_rdata  out  32  IFU read data (= mem_rdata)
- lsu_reqValid  in  1  one-cycle pulse starting an LSU access
- lsu_addr  in  32  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  32  write data
- lsu_wmask  in  4  byte write mask
- lsu_respValid  out  1  LSU access complete (read data valid when read)
- lsu_rdata  out  32  LSU read data (= mem_rdata)
- mem_reqValid  out  1  one-cycle pulse issuing a transaction downstream
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  32/1/32/4  transaction fields, valid with mem_reqValid, all 0 otherwise
- mem_respValid  in  1  downstream completion; may arrive in the issue cycle or any later cycle
- mem_rdata  in  32  downstream read data

## Operation
- State machine states:
  - IDLE: no transaction in flight.
  - WAIT_IFU / WAIT_LSU: a transaction is in flight for that owner.
- Pending slots: one per requester. The IFU slot holds pend flag + addr. The LSU slot holds pend flag + addr/wen/wdata/wmask.
- Candidates: a requester is a candidate when its reqValid pulse is live or its pend flag is set. The live pulse's fields take precedence over the slot.
- IDLE with at least one candidate:
  - Select the winner per LSU_PRIO.
  - Drive mem_reqValid=1 and the winner's fields combinationally in the same cycle.
  - Update last_grant and clear the winner's pend flag.
  - A loser with a live pulse is latched into its slot.
  - If mem_respValid=1 in that cycle: route the response and stay IDLE. Otherwise go to WAIT_<winner>.
- WAIT_x:
  - mem_reqValid=0.
  - A live pulse from either requester is latched into its slot.
  - On mem_respValid: drive x_respValid=1 and go to IDLE.
- Routing: x_respValid = mem_respValid only while x owns the transaction; the other respValid stays 0. Both rdata outputs always equal mem_rdata.
- mem_respValid in IDLE with nothing issued that cycle is ignored.
- Requester contract: at most one outstanding request per requester. A pulse from a requester that is live, pending or in flight is a protocol violation; the bench flags it with an assertion.

## Timing
- Reset (reset==0 at a rising edge):
  - Clears state to IDLE, pend flags to 0, last_grant to IFU.
  - mem_reqValid, ifu_respValid, lsu_respValid and all mem_* fields are 0 during and after reset until a request arrives.
- Latency, uncontended: a pulse in cycle N issues mem_reqValid in cycle N.
  - Response in the same cycle N if the memory answers combinationally.
  - Otherwise the response is one cycle after mem_respValid... no: the response is in the same cycle as mem_respValid.
- Latency, buffered: a request latched into a slot issues in the first IDLE cycle after the blocking response, i.e. one cycle after it. This one-cycle bubble is required.
- Simultaneous response + live pulse from the other requester in WAIT_x: the pulse is latched and issued the next cycle.
- Simultaneous pulses in IDLE: one issues, the other is latched. The latched request issues the next cycle after completion.
- Round-robin example (LSU_PRIO=0): after reset, simultaneous pulses grant LSU (last_grant=IFU).
- Reset mid-transaction:
  - Drops the in-flight ownership and both slots.
  - A late mem_respValid after reset is ignored and produces no respValid.

## Test plan
- Reset with both reqValid=1 held -> all outputs 0 while reset==0; first cycle after release issues one request, with mem_addr and mem_reqValid=1 matching the winner.
- IFU pulse addr=0x8000_0000, mem_respValid 3 cycles later with rdata=0x0000_0013 -> ifu_respValid=1 and ifu_rdata=0x13 in that cycle; lsu_respValid stays 0.
- LSU_PRIO=1, same-cycle pulses IFU 0x8000_0004 and LSU write 0x0F00_0000 / wdata=0xDEAD_BEEF / wmask=0xF:
  - LSU issues first with mem_wen=1.
  - After its response, IFU issues exactly one cycle later from the slot with mem_addr=0x8000_0004.
- LSU_PRIO=0, three rounds of simultaneous pulses -> grants alternate LSU, IFU, LSU.
- Zero-latency memory (mem_respValid tied to mem_reqValid) -> each uncontended request completes in its issue cycle; state never leaves IDLE.
- Reset asserted during WAIT_LSU with IFU pending, then mem_respValid pulsed -> no respValid; no issue of the dropped IFU request.
